// File: rtl/hsv_multi_classifier.sv
// Three-stage HSV window classifier with NCLASS runtime windows and per-frame match counters.
// Define RGB_CLASS_OVERLAY_EN to paint matching pixels with a fixed per-class colour.
module hsv_multi_classifier #(
  parameter int NCLASS  = 2,
  parameter int ROW_MAX = 477,
  parameter int COL_MAX = 617,
  parameter int CNT_W   = 19
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      i_valid,
  input  logic                      i_frame_start,
  input  logic [7:0]                i_R,
  input  logic [7:0]                i_G,
  input  logic [7:0]                i_B,
  input  logic [12:0]               i_row,
  input  logic [12:0]               i_col,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [24:0]               cfg_data,
  output logic                      o_valid,
  output logic [7:0]                o_R,
  output logic [7:0]                o_G,
  output logic [7:0]                o_B,
  output logic [NCLASS-1:0]         o_class,
  output logic [NCLASS*CNT_W-1:0]   o_count,
  output logic                      o_count_valid
);

  logic [24:0]              r_shadow [NCLASS];
  logic [24:0]              r_active [NCLASS];
  // {sshift, vmin, sector} of the active config, one cycle behind so S3 sees its own frame's window
  logic [12:0]              r_cfg_d  [NCLASS];

  logic                     r1_valid, r1_fs, r1_crop;
  logic [7:0]               r1_R, r1_G, r1_B, r1_s, r1_v;
  logic [1:0]               r1_sec;

  logic                     r2_valid, r2_fs, r2_crop;
  logic [7:0]               r2_R, r2_G, r2_B, r2_s, r2_v;
  logic [1:0]               r2_sec;
  logic [9:0]               r2_hn;
  logic signed [15:0]       r2_tlo [NCLASS];
  logic signed [15:0]       r2_thi [NCLASS];

  logic [CNT_W-1:0]         r_cnt [NCLASS];
  logic                     r_valid, r_count_valid;
  logic [7:0]               r_R, r_G, r_B;
  logic [NCLASS-1:0]        r_class;
  logic [NCLASS*CNT_W-1:0]  r_count;

  logic                     w_fs, w_crop, w_any;
  logic [1:0]               w_sec;
  logic [7:0]               w_mx, w_mn, w_oR, w_oG, w_oB;
  logic [9:0]               w_hn;
  logic signed [15:0]       w_tlo [NCLASS];
  logic signed [15:0]       w_thi [NCLASS];
  logic [NCLASS-1:0]        w_hit, w_class;

  always_comb begin
    w_fs   = i_valid & i_frame_start;
    w_crop = (32'(i_row) > ROW_MAX) || (32'(i_col) > COL_MAX);
    if (i_R >= i_G && i_R >= i_B) begin
      w_sec = 2'd0;
      w_mx  = i_R;
    end else if (i_G >= i_B) begin
      w_sec = 2'd1;
      w_mx  = i_G;
    end else begin
      w_sec = 2'd2;
      w_mx  = i_B;
    end
    w_mn = i_R;
    if (i_G < w_mn) w_mn = i_G;
    if (i_B < w_mn) w_mn = i_B;
  end

  always_comb begin
    case (r1_sec)
      2'd0:    w_hn = {2'b00, r1_G} - {2'b00, r1_B};
      2'd1:    w_hn = {2'b00, r1_B} - {2'b00, r1_R};
      default: w_hn = {2'b00, r1_R} - {2'b00, r1_G};
    endcase
    for (int unsigned k = 0; k < NCLASS; k++) begin
      w_tlo[k] = ($signed({{10{r_active[k][7]}},  r_active[k][7:2]})  * $signed({8'b0, r1_s})) >>> 2;
      w_thi[k] = ($signed({{10{r_active[k][13]}}, r_active[k][13:8]}) * $signed({8'b0, r1_s})) >>> 2;
    end
  end

  always_comb begin
    w_hit   = '0;
    w_class = '0;
    w_any   = 1'b0;
    for (int unsigned k = 0; k < NCLASS; k++) begin
      w_hit[k] = r2_valid && !r2_crop && (r_cfg_d[k][1:0] == r2_sec) &&
                 ($signed({{6{r2_hn[9]}}, r2_hn}) > r2_tlo[k]) &&
                 ($signed({{6{r2_hn[9]}}, r2_hn}) < r2_thi[k]) &&
                 (r2_v >= r_cfg_d[k][9:2]) &&
                 (r2_s > (r2_v >> r_cfg_d[k][12:10]));
      if (w_hit[k] && !w_any) begin
        w_class[k] = 1'b1;
        w_any      = 1'b1;
      end
    end
    w_oR = r2_crop ? '0 : r2_R;
    w_oG = r2_crop ? '0 : r2_G;
    w_oB = r2_crop ? '0 : r2_B;
`ifdef RGB_CLASS_OVERLAY_EN
    for (int unsigned k = 0; k < NCLASS; k++) begin
      if (w_class[k]) begin
        case (k)
          0:       {w_oR, w_oG, w_oB} = 24'hFF0000;
          1:       {w_oR, w_oG, w_oB} = 24'h00FF00;
          2:       {w_oR, w_oG, w_oB} = 24'h0000FF;
          default: {w_oR, w_oG, w_oB} = 24'hFFFFFF;
        endcase
      end
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned k = 0; k < NCLASS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
        r_cfg_d[k]  <= '0;
        r2_tlo[k]   <= '0;
        r2_thi[k]   <= '0;
        r_cnt[k]    <= '0;
      end
      {r1_valid, r1_fs, r1_crop, r1_R, r1_G, r1_B, r1_s, r1_v, r1_sec} <= '0;
      {r2_valid, r2_fs, r2_crop, r2_R, r2_G, r2_B, r2_s, r2_v, r2_sec, r2_hn} <= '0;
      {r_valid, r_count_valid, r_R, r_G, r_B} <= '0;
      r_class <= '0;
      r_count <= '0;
    end else begin
      // A write coincident with an accepted frame start goes straight into the active copy
      for (int unsigned k = 0; k < NCLASS; k++) begin
        if (cfg_we && cfg_addr == 3'(k)) r_shadow[k] <= cfg_data;
        if (w_fs) r_active[k] <= (cfg_we && cfg_addr == 3'(k)) ? cfg_data : r_shadow[k];
        r_cfg_d[k] <= {r_active[k][24:22], r_active[k][21:14], r_active[k][1:0]};
      end

      r1_valid <= i_valid;
      r1_fs    <= w_fs;
      r1_crop  <= w_crop;
      r1_R     <= i_R;
      r1_G     <= i_G;
      r1_B     <= i_B;
      r1_s     <= w_mx - w_mn;
      r1_v     <= w_mx;
      r1_sec   <= w_sec;

      r2_valid <= r1_valid;
      r2_fs    <= r1_fs;
      r2_crop  <= r1_crop;
      r2_R     <= r1_R;
      r2_G     <= r1_G;
      r2_B     <= r1_B;
      r2_s     <= r1_s;
      r2_v     <= r1_v;
      r2_sec   <= r1_sec;
      r2_hn    <= w_hn;
      for (int unsigned k = 0; k < NCLASS; k++) begin
        r2_tlo[k] <= w_tlo[k];
        r2_thi[k] <= w_thi[k];
      end

      r_valid       <= r2_valid;
      r_R           <= w_oR;
      r_G           <= w_oG;
      r_B           <= w_oB;
      r_class       <= w_class;
      r_count_valid <= r2_fs;
      for (int unsigned k = 0; k < NCLASS; k++) begin
        if (r2_fs) begin
          r_count[k*CNT_W +: CNT_W] <= r_cnt[k];
          r_cnt[k] <= CNT_W'(w_class[k]);
        end else if (w_class[k] && r_cnt[k] != '1) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_R           = r_R;
  assign o_G           = r_G;
  assign o_B           = r_B;
  assign o_class       = r_class;
  assign o_count       = r_count;
  assign o_count_valid = r_count_valid;

endmodule

// File: tb/tb_hsv_multi_classifier.sv
// Scoreboard bench for hsv_multi_classifier: a behavioural model predicts class, RGB and frame counts.
module tb_hsv_multi_classifier;
  localparam int NCLASS  = 2;
  localparam int ROW_MAX = 477;
  localparam int COL_MAX = 617;
  localparam int CNT_W   = 19;

  logic                     iCLK = 1'b0;
  logic                     iRST = 1'b1;
  logic                     i_valid = 1'b0, i_frame_start = 1'b0;
  logic [7:0]               i_R = '0, i_G = '0, i_B = '0;
  logic [12:0]              i_row = '0, i_col = '0;
  logic                     cfg_we = 1'b0;
  logic [2:0]               cfg_addr = '0;
  logic [24:0]              cfg_data = '0;
  logic                     o_valid, o_count_valid;
  logic [7:0]               o_R, o_G, o_B;
  logic [NCLASS-1:0]        o_class;
  logic [NCLASS*CNT_W-1:0]  o_count;

  hsv_multi_classifier #(
    .NCLASS(NCLASS), .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX), .CNT_W(CNT_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .i_valid(i_valid), .i_frame_start(i_frame_start),
    .i_R(i_R), .i_G(i_G), .i_B(i_B), .i_row(i_row), .i_col(i_col),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .o_valid(o_valid), .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_class(o_class),
    .o_count(o_count), .o_count_valid(o_count_valid)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [NCLASS-1:0] cls;
    logic [23:0]       rgb;
    int                cyc;
  } px_t;

  px_t         q_px[$];
  logic [63:0] q_cnt[$];
  int          q_cnt_cyc[$];
  logic [24:0] m_sh[NCLASS];
  logic [24:0] m_act[NCLASS];
  int          m_cnt[NCLASS];
  int          cyc = 0, n_tests = 0, n_fail = 0;
  px_t         mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [24:0] mkcfg(input int sec, input int lo, input int hi, input int vmin, input int sh);
    return {3'(sh), 8'(vmin), 6'(hi), 6'(lo), 2'(sec)};
  endfunction

  function automatic int floor4(input int t);
    return (t >= 0) ? t / 4 : -((3 - t) / 4);
  endfunction

  function automatic int sext6(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  function automatic logic [NCLASS-1:0] model_class(input int r, input int g, input int b);
    int mx, mn, s, sec, hn;
    logic [NCLASS-1:0] one;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    s = mx - mn;
    if (r >= g && r >= b) begin sec = 0; hn = g - b; end
    else if (g >= b)      begin sec = 1; hn = b - r; end
    else                  begin sec = 2; hn = r - g; end
    for (int k = 0; k < NCLASS; k++) begin
      if (int'(m_act[k][1:0]) == sec &&
          hn > floor4(sext6(m_act[k][7:2]) * s) &&
          hn < floor4(sext6(m_act[k][13:8]) * s) &&
          mx >= int'(m_act[k][21:14]) &&
          s > (mx >> m_act[k][24:22])) begin
        one = '0;
        one[k] = 1'b1;
        return one;
      end
    end
    return '0;
  endfunction

  function automatic logic [23:0] model_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                            input logic [NCLASS-1:0] cls, input bit crop);
    if (crop) return '0;
`ifdef RGB_CLASS_OVERLAY_EN
    for (int k = 0; k < NCLASS; k++)
      if (cls[k]) return (k == 0) ? 24'hFF0000 : (k == 1) ? 24'h00FF00 : (k == 2) ? 24'h0000FF : 24'hFFFFFF;
`endif
    return {r, g, b};
  endfunction

  task automatic drive(input bit v, input bit fs, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input int row, input int col, input bit we, input logic [2:0] addr, input logic [24:0] data);
    logic [NCLASS-1:0] cls;
    logic [63:0]       p;
    bit                crop;
    px_t               e;
    @(negedge iCLK);
    i_valid = v; i_frame_start = fs; i_R = r; i_G = g; i_B = b;
    i_row = 13'(row); i_col = 13'(col);
    cfg_we = we; cfg_addr = addr; cfg_data = data;
    for (int k = 0; k < NCLASS; k++)
      if (we && int'(addr) == k) m_sh[k] = data;
    if (v && fs) begin
      p = '0;
      for (int k = 0; k < NCLASS; k++) begin
        p[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        m_cnt[k] = 0;
        m_act[k] = m_sh[k];
      end
      q_cnt.push_back(p);
      q_cnt_cyc.push_back(cyc + 3);
    end
    if (v) begin
      crop = (row > ROW_MAX) || (col > COL_MAX);
      cls  = crop ? '0 : model_class(r, g, b);
      for (int k = 0; k < NCLASS; k++) if (cls[k]) m_cnt[k]++;
      e.cls = cls;
      e.rgb = model_rgb(r, g, b, cls, crop);
      e.cyc = cyc + 3;
      q_px.push_back(e);
    end
  endtask

  task automatic pix(input bit fs, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    drive(1'b1, fs, r, g, b, 10, 10, 1'b0, 3'd0, '0);
  endtask

  task automatic pix_at(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int row, input int col);
    drive(1'b1, 1'b0, r, g, b, row, col, 1'b0, 3'd0, '0);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [24:0] data);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0, 1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0, 1'b0, 3'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST = 1'b1;
    i_valid = 1'b0; i_frame_start = 1'b0; cfg_we = 1'b0;
    q_px.delete(); q_cnt.delete(); q_cnt_cyc.delete();
    for (int k = 0; k < NCLASS; k++) begin
      m_sh[k] = '0; m_act[k] = '0; m_cnt[k] = 0;
    end
    @(negedge iCLK);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_class", 64'(o_class), 64'd0);
    check("rst_rgb",   64'({o_R, o_G, o_B}), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_cntv",  64'(o_count_valid), 64'd0);
    iRST = 1'b0;
  endtask

  always begin
    @(posedge iCLK);
    cyc++;
    #1;
    if (o_valid === 1'b1) begin
      if (q_px.size() == 0) check("spurious_valid", 64'(o_valid), 64'd0);
      else begin
        mon_e = q_px.pop_front();
        check("class",   64'(o_class), 64'(mon_e.cls));
        check("rgb",     64'({o_R, o_G, o_B}), 64'(mon_e.rgb));
        check("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (o_count_valid === 1'b1) begin
      if (q_cnt.size() == 0) check("spurious_count", 64'(o_count_valid), 64'd0);
      else begin
        check("count",     64'(o_count), q_cnt.pop_front());
        check("count_lat", 64'(cyc), 64'(q_cnt_cyc.pop_front()));
      end
    end
  end

  initial begin
    do_reset();
    // class0 window written in the frame-start cycle itself
    drive(1'b1, 1'b1, 8'd200, 8'd40, 8'd30, 10, 10, 1'b1, 3'd0, mkcfg(0, 0, 1, 65, 1));
    pix_at(8'd200, 8'd40, 8'd30, 478, 10);
    pix_at(8'd200, 8'd40, 8'd30, 10, 618);
    pix_at(8'd200, 8'd40, 8'd30, 477, 617);
    pix(1'b0, 8'd200, 8'd50, 8'd0);
    pix(1'b0, 8'd200, 8'd30, 8'd30);
    pix(1'b0, 8'd65, 8'd10, 8'd5);
    pix(1'b0, 8'd64, 8'd10, 8'd5);
    pix(1'b0, 8'd200, 8'd200, 8'd10);
    pix(1'b0, 8'd100, 8'd100, 8'd100);

    cfg_write(3'd1, mkcfg(0, 0, 1, 65, 1));
    pix(1'b1, 8'd200, 8'd40, 8'd30);
    pix(1'b0, 8'd100, 8'd100, 8'd100);

    cfg_write(3'd1, mkcfg(1, -1, 1, 65, 1));
    cfg_write(3'd5, mkcfg(0, -31, 31, 0, 7));
    drive(1'b0, 1'b1, 8'd40, 8'd200, 8'd30, 10, 10, 1'b0, 3'd0, '0);
    pix(1'b0, 8'd40, 8'd200, 8'd30);
    pix(1'b1, 8'd40, 8'd200, 8'd30);
    pix(1'b0, 8'd200, 8'd40, 8'd30);

    pix(1'b1, 8'd200, 8'd40, 8'd30);
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    pix(1'b0, 8'd100, 8'd100, 8'd100);
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    pix(1'b1, 8'd200, 8'd40, 8'd30);
    idle(4);

    cfg_write(3'd0, mkcfg(0, 0, 1, 250, 1));
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    pix(1'b1, 8'd200, 8'd40, 8'd30);
    pix(1'b0, 8'd40, 8'd200, 8'd30);

    pix(1'b0, 8'd40, 8'd200, 8'd30);
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    do_reset();
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    drive(1'b1, 1'b1, 8'd200, 8'd40, 8'd30, 10, 10, 1'b1, 3'd0, mkcfg(0, 0, 1, 65, 1));
    pix(1'b0, 8'd200, 8'd40, 8'd30);
    pix(1'b1, 8'd200, 8'd40, 8'd30);
    idle(6);

    check("px_drain",  64'(q_px.size()), 64'd0);
    check("cnt_drain", 64'(q_cnt.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
